// File: rtl/ppl_stage_reg_pkg.sv
// Shared types for the MoonCore inter-stage pipeline register: state encoding,
// the default bubble instruction and the occupancy mapping.
package ppl_stage_reg_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        PPL_EMPTY = 2'd0,
        PPL_FULL  = 2'd1,
        PPL_SKID  = 2'd2
    } ppl_state_e;

    function automatic logic [1:0] occ_of(input ppl_state_e s);
        case (s)
            PPL_FULL: occ_of = 2'd1;
            PPL_SKID: occ_of = 2'd2;
            default:  occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ppl_stage_reg_if.sv
// Valid/ready stage link carrying an instruction address and payload.
// The producer side uses master, the consumer side uses slave.
interface ppl_stage_reg_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/ppl_stage_reg_entry.sv
// ppl_entry_reg: one {valid, addr, data} slot. Clear wins over load and
// returns the slot to the bubble pattern (addr 0, data NOP).
module ppl_entry_reg #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] NOP_VAL = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              d_vld,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_vld_p0,
    output logic [ADDR_W-1:0] q_addr_p0,
    output logic [DATA_W-1:0] q_data_p0
);
    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld_p0  <= 1'b0;
            q_addr_p0 <= '0;
            q_data_p0 <= NOP_W;
        end else if (clear) begin
            q_vld_p0  <= 1'b0;
            q_addr_p0 <= '0;
            q_data_p0 <= NOP_W;
        end else if (load) begin
            q_vld_p0  <= d_vld;
            q_addr_p0 <= d_addr;
            q_data_p0 <= d_data;
        end
    end

endmodule

// File: rtl/ppl_stage_reg.sv
// Parametrised MoonCore pipeline stage register: valid/ready handshake with an
// optional 2-entry skid buffer, stall (freeze) and flush (kill to bubble).
module ppl_stage_reg
    import ppl_stage_reg_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] NOP_VAL = NOP_INST,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    ppl_stage_reg_if.slave  up,
    ppl_stage_reg_if.master dn,
    output logic [1:0]      occupancy
);
    ppl_state_e state_p0, state_nx;

    logic              in_rdy, in_fire, out_fire;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_vld_p0, skid_vld_p0;
    logic [ADDR_W-1:0] main_addr_p0, skid_addr_p0;
    logic [DATA_W-1:0] main_data_p0, skid_data_p0;
    logic              main_d_vld;
    logic [ADDR_W-1:0] main_d_addr;
    logic [DATA_W-1:0] main_d_data;

    // Skid mode registers readiness in the state; single-entry mode passes
    // downstream readiness straight through.
    always_comb begin
        in_rdy = 1'b0;
        if (SKID_EN)
            in_rdy = !stall && !flush && (state_p0 != PPL_SKID);
        else
            in_rdy = !stall && !flush && (!main_vld_p0 || dn.ready);
    end

    assign in_fire  = up.valid && in_rdy;
    assign out_fire = main_vld_p0 && dn.ready && !stall;

    // ---- stage boundary: state and occupancy register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0  <= PPL_EMPTY;
            occupancy <= 2'd0;
        end else begin
            state_p0  <= state_nx;
            occupancy <= occ_of(state_nx);
        end
    end

    always_comb begin
        state_nx = state_p0;
        if (flush) begin
            state_nx = PPL_EMPTY;
        end else begin
            case (state_p0)
                PPL_EMPTY: if (in_fire) state_nx = PPL_FULL;
                PPL_FULL: begin
                    if (in_fire && !out_fire)
                        state_nx = SKID_EN ? PPL_SKID : PPL_FULL;
                    else if (!in_fire && out_fire)
                        state_nx = PPL_EMPTY;
                end
                PPL_SKID: if (out_fire) state_nx = PPL_FULL;
                default:  state_nx = PPL_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_p0)
                PPL_EMPTY: main_load = in_fire;
                PPL_FULL: begin
                    if (in_fire && out_fire)
                        main_load = 1'b1;
                    else if (in_fire)
                        skid_load = 1'b1;
                    else if (out_fire)
                        main_clear = 1'b1;
                end
                PPL_SKID: begin
                    // Main drains before skid, so order is preserved.
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_d_vld  = main_from_skid ? skid_vld_p0  : 1'b1;
    assign main_d_addr = main_from_skid ? skid_addr_p0 : up.addr;
    assign main_d_data = main_from_skid ? skid_data_p0 : up.data;

    // ---- stage boundary: main (output) and skid entries ----
    ppl_entry_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (main_load),
        .clear     (main_clear),
        .d_vld     (main_d_vld),
        .d_addr    (main_d_addr),
        .d_data    (main_d_data),
        .q_vld_p0  (main_vld_p0),
        .q_addr_p0 (main_addr_p0),
        .q_data_p0 (main_data_p0)
    );

    ppl_entry_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .d_vld     (1'b1),
        .d_addr    (up.addr),
        .d_data    (up.data),
        .q_vld_p0  (skid_vld_p0),
        .q_addr_p0 (skid_addr_p0),
        .q_data_p0 (skid_data_p0)
    );

    assign up.ready = in_rdy;
    assign dn.valid = main_vld_p0;
    assign dn.addr  = main_addr_p0;
    assign dn.data  = main_data_p0;

endmodule

// File: tb/tb_ppl_stage_reg.sv
// Directed bench for ppl_stage_reg: one skid-enabled instance and one
// single-entry instance, checked against hand-computed expectations.
module tb_ppl_stage_reg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic stall, flush, stall0, flush0;
    logic [1:0] occ, occ0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ppl_stage_reg_if #(.ADDR_W(32), .DATA_W(32)) up_if ();
    ppl_stage_reg_if #(.ADDR_W(32), .DATA_W(32)) dn_if ();
    ppl_stage_reg_if #(.ADDR_W(32), .DATA_W(32)) up0_if ();
    ppl_stage_reg_if #(.ADDR_W(32), .DATA_W(32)) dn0_if ();

    ppl_stage_reg #(.ADDR_W(32), .DATA_W(32), .NOP_VAL(NOP), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .up(up_if.slave), .dn(dn_if.master), .occupancy(occ)
    );

    ppl_stage_reg #(.ADDR_W(32), .DATA_W(32), .NOP_VAL(NOP), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall0), .flush(flush0),
        .up(up0_if.slave), .dn(dn0_if.master), .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        up_if.valid = v;
        up_if.addr  = a;
        up_if.data  = a ^ 32'hDA7A_0000;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a);
        up0_if.valid = v;
        up0_if.addr  = a;
        up0_if.data  = a ^ 32'hDA7A_0000;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] a, input logic [1:0] o);
        check({tag, ".valid"}, {31'd0, dn_if.valid}, {31'd0, v});
        check({tag, ".addr"}, dn_if.addr, a);
        check({tag, ".data"}, dn_if.data, v ? (a ^ 32'hDA7A_0000) : NOP);
        check({tag, ".occ"}, {30'd0, occ}, {30'd0, o});
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; stall0 = 1'b0; flush0 = 1'b0;
        drive(1'b0, 32'h0); drive0(1'b0, 32'h0);
        dn_if.ready = 1'b0; dn0_if.ready = 1'b0;

        // Reset and idle
        #12;
        expect_out("rst", 1'b0, 32'h0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", {31'd0, up_if.ready}, 32'd1);
        check("rst.in_ready0", {31'd0, up0_if.ready}, 32'd1);

        // Stream with downstream always ready
        dn_if.ready = 1'b1;
        drive(1'b1, 32'h0); step(); expect_out("s0", 1'b1, 32'h0, 2'd1);
        drive(1'b1, 32'h4); step(); expect_out("s4", 1'b1, 32'h4, 2'd1);
        drive(1'b1, 32'h8); step(); expect_out("s8", 1'b1, 32'h8, 2'd1);
        drive(1'b0, 32'h0); step(); expect_out("s_end", 1'b0, 32'h0, 2'd0);

        // Back-pressure fills the skid entry
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h10); step(); expect_out("bp10", 1'b1, 32'h10, 2'd1);
        drive(1'b1, 32'h14); step(); expect_out("bp14", 1'b1, 32'h10, 2'd2);
        drive(1'b1, 32'h18); #1;
        check("bp.in_ready", {31'd0, up_if.ready}, 32'd0);
        step(); expect_out("bp_hold", 1'b1, 32'h10, 2'd2);
        dn_if.ready = 1'b1; #1;
        check("bp.in_ready_skid", {31'd0, up_if.ready}, 32'd0);
        step(); expect_out("bp_rel14", 1'b1, 32'h14, 2'd1);
        check("bp.in_ready_full", {31'd0, up_if.ready}, 32'd1);
        step(); expect_out("bp_rel18", 1'b1, 32'h18, 2'd1);
        drive(1'b0, 32'h0); step(); expect_out("bp_empty", 1'b0, 32'h0, 2'd0);

        // Flush with two held entries drops the presented one too
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h30); step();
        drive(1'b1, 32'h34); step(); expect_out("fl_pre", 1'b1, 32'h30, 2'd2);
        flush = 1'b1; stall = 1'b1; drive(1'b1, 32'h20); #1;
        check("fl.in_ready", {31'd0, up_if.ready}, 32'd0);
        step();
        flush = 1'b0; stall = 1'b0; drive(1'b0, 32'h0); dn_if.ready = 1'b1;
        expect_out("fl_post", 1'b0, 32'h0, 2'd0);
        step(); expect_out("fl_quiet", 1'b0, 32'h0, 2'd0);

        // Stall freezes a FULL stage even with downstream ready
        drive(1'b1, 32'h40); step(); expect_out("st40", 1'b1, 32'h40, 2'd1);
        stall = 1'b1; drive(1'b1, 32'h44); #1;
        check("st.in_ready", {31'd0, up_if.ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("st_hold", 1'b1, 32'h40, 2'd1);
        end
        stall = 1'b0; drive(1'b0, 32'h0);
        step(); expect_out("st_fire", 1'b0, 32'h0, 2'd0);
        step(); expect_out("st_once", 1'b0, 32'h0, 2'd0);

        // Asynchronous reset with occupancy 2
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h50); step();
        drive(1'b1, 32'h54); step(); expect_out("ar_pre", 1'b1, 32'h50, 2'd2);
        #2 rst_n = 1'b0;
        #1 expect_out("ar_now", 1'b0, 32'h0, 2'd0);
        drive(1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single-entry variant: in_ready follows !out_valid | out_ready
        dn0_if.ready = 1'b1;
        drive0(1'b1, 32'h0); step(); check("n0.addr", dn0_if.addr, 32'h0);
        drive0(1'b1, 32'h4); step(); check("n4.addr", dn0_if.addr, 32'h4);
        drive0(1'b1, 32'h8); step(); check("n8.addr", dn0_if.addr, 32'h8);
        check("n8.occ", {30'd0, occ0}, 32'd1);
        check("n8.in_ready", {31'd0, up0_if.ready}, 32'd1);
        dn0_if.ready = 1'b0; drive0(1'b1, 32'hC); #1;
        check("n.in_ready_blk", {31'd0, up0_if.ready}, 32'd0);
        step();
        check("n.hold_addr", dn0_if.addr, 32'h8);
        check("n.hold_occ", {30'd0, occ0}, 32'd1);
        dn0_if.ready = 1'b1; #1;
        check("n.in_ready_rel", {31'd0, up0_if.ready}, 32'd1);
        step(); check("nC.addr", dn0_if.addr, 32'hC);
        drive0(1'b0, 32'h0); step();
        check("n.empty_valid", {31'd0, dn0_if.valid}, 32'd0);
        check("n.empty_data", dn0_if.data, NOP);
        dn0_if.ready = 1'b0; #1;
        check("n.empty_in_ready", {31'd0, up0_if.ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
